// File: rtl/red_pitaya_iq_gain_sequencer.sv
// red_pitaya_iq_gain_sequencer
//   Ramps the four IQ modulator gains (g1..g4) toward bus-written targets in
//   bounded steps, so that amplitude, offset and quadrature scaling never jump.
//   A ramp can optionally be held off until the modulator sine crosses zero
//   on a rising edge.
//
// Ports
//   clk_i                 clock
//   rst_i                 synchronous reset, active-high
//   tgt_g1_i..tgt_g4_i    signed target gains, sampled on commit
//   step_i                unsigned max change per update, 0 = jump to target
//   div_i                 update period is div_i+1 clocks
//   sync_en_i             hold the ramp until a rising zero crossing of sin_i
//   sin_i                 signed modulator sine sample
//   commit_i              pulse: latch targets/step/div and start (or retarget)
//   abort_i               pulse: freeze gains and return to idle, wins over commit
//   g1_o..g4_o            signed active gains, registered
//   busy_o                high while waiting for sync or ramping
//   done_o                one-cycle pulse when all gains reach their targets
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | gains hold, waiting for commit
// WAIT_SYNC | waiting for sin_i to go from negative to non-negative
// RAMP      | prescaler running, gains step toward targets on terminal count
module red_pitaya_iq_gain_sequencer #(
  parameter int GAINBITS = 16,
  parameter int SINBITS  = 14,
  parameter int DIVBITS  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [GAINBITS-1:0] tgt_g1_i,
  input  logic [GAINBITS-1:0] tgt_g2_i,
  input  logic [GAINBITS-1:0] tgt_g3_i,
  input  logic [GAINBITS-1:0] tgt_g4_i,
  input  logic [GAINBITS-1:0] step_i,
  input  logic [DIVBITS-1:0]  div_i,
  input  logic                sync_en_i,
  input  logic [SINBITS-1:0]  sin_i,
  input  logic                commit_i,
  input  logic                abort_i,
  output logic [GAINBITS-1:0] g1_o,
  output logic [GAINBITS-1:0] g2_o,
  output logic [GAINBITS-1:0] g3_o,
  output logic [GAINBITS-1:0] g4_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, RAMP} state_t;
  typedef logic [3:0][GAINBITS-1:0] gain_vec_t;

  localparam logic [GAINBITS:0] ONE_X   = (GAINBITS+1)'(1);
  localparam logic [DIVBITS-1:0] ONE_D  = DIVBITS'(1);

  state_t              state_q, state_d;
  gain_vec_t           g_q, g_d, tgt_q, tgt_d, tgt_in, tgt_eff, g_next;
  logic [GAINBITS-1:0] step_q, step_d, step_eff;
  logic [DIVBITS-1:0]  div_q, div_d, div_eff, cnt_q, cnt_d;
  logic                sin_prev_neg_q;
  logic                busy_q, done_q, done_d;
  logic                relatch, sync_hit, all_hit;

  // Only the sign of the previous sine sample matters for crossing detection.
  assign sync_hit = sin_prev_neg_q && ($signed(sin_i) >= 0);

  assign tgt_in  = {tgt_g4_i, tgt_g3_i, tgt_g2_i, tgt_g1_i};
  assign relatch = commit_i && !abort_i;

  // A commit that lands on an update edge steers that update to the new targets.
  assign tgt_eff  = relatch ? tgt_in : tgt_q;
  assign step_eff = relatch ? step_i : step_q;
  assign div_eff  = relatch ? div_i  : div_q;

  // Difference is taken one bit wider so full-scale swings cannot overflow.
  // The stepped result always lies between g and tgt, so the narrow add is exact.
  function automatic logic [GAINBITS-1:0] step_toward(
    input logic [GAINBITS-1:0] g,
    input logic [GAINBITS-1:0] tgt,
    input logic [GAINBITS-1:0] stp
  );
    logic [GAINBITS:0] d, mag;
    d   = {tgt[GAINBITS-1], tgt} - {g[GAINBITS-1], g};
    mag = d[GAINBITS] ? (~d + ONE_X) : d;
    if (stp == '0 || mag <= {1'b0, stp})
      step_toward = tgt;
    else if (d[GAINBITS])
      step_toward = g - stp;
    else
      step_toward = g + stp;
  endfunction

  always_comb begin
    all_hit = 1'b1;
    g_next  = g_q;
    for (int i = 0; i < 4; i++) begin
      g_next[i] = step_toward(g_q[i], tgt_eff[i], step_eff);
      if (g_next[i] != tgt_eff[i]) all_hit = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (relatch) begin
      tgt_d  = tgt_in;
      step_d = step_i;
      div_d  = div_i;
    end

    unique case (state_q)
      IDLE: begin
        if (relatch) begin
          if (sync_en_i) begin
            state_d = WAIT_SYNC;
          end else begin
            state_d = RAMP;
            cnt_d   = div_i;
          end
        end
      end
      WAIT_SYNC: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (sync_hit) begin
          state_d = RAMP;
          cnt_d   = div_eff;
        end
      end
      RAMP: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE_D;
        end else begin
          cnt_d = div_eff;
          g_d   = g_next;
          if (all_hit) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      g_q            <= '0;
      tgt_q          <= '0;
      step_q         <= '0;
      div_q          <= '0;
      cnt_q          <= '0;
      sin_prev_neg_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      g_q            <= g_d;
      tgt_q          <= tgt_d;
      step_q         <= step_d;
      div_q          <= div_d;
      cnt_q          <= cnt_d;
      sin_prev_neg_q <= sin_i[SINBITS-1];
      busy_q         <= (state_d != IDLE);
      done_q         <= done_d;
    end
  end

  assign g1_o   = g_q[0];
  assign g2_o   = g_q[1];
  assign g3_o   = g_q[2];
  assign g4_o   = g_q[3];
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_red_pitaya_iq_gain_sequencer.sv
module tb_red_pitaya_iq_gain_sequencer;
  localparam int GB = 16;
  localparam int SB = 14;
  localparam int DB = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [GB-1:0] tgt_g1_i = '0, tgt_g2_i = '0, tgt_g3_i = '0, tgt_g4_i = '0;
  logic [GB-1:0] step_i = '0;
  logic [DB-1:0] div_i = '0;
  logic          sync_en_i = 1'b0;
  logic [SB-1:0] sin_i = '0;
  logic          commit_i = 1'b0, abort_i = 1'b0;
  logic [GB-1:0] g1_o, g2_o, g3_o, g4_o;
  logic          busy_o, done_o;

  red_pitaya_iq_gain_sequencer #(.GAINBITS(GB), .SINBITS(SB), .DIVBITS(DB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tgt_g1_i(tgt_g1_i), .tgt_g2_i(tgt_g2_i), .tgt_g3_i(tgt_g3_i), .tgt_g4_i(tgt_g4_i),
    .step_i(step_i), .div_i(div_i), .sync_en_i(sync_en_i), .sin_i(sin_i),
    .commit_i(commit_i), .abort_i(abort_i),
    .g1_o(g1_o), .g2_o(g2_o), .g3_o(g3_o), .g4_o(g4_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef logic [3:0][GB-1:0] gvec_t;
  typedef struct packed {
    gvec_t       g;
    logic        done;
    logic        busy;
    logic [31:0] edge_no;
  } ev_t;

  ev_t   expq[$];
  ev_t   mon_ev;
  int    checks = 0;
  int    errors = 0;
  int    edge_cnt = 0;
  bit    mon_en = 1'b0;
  gvec_t prev_g, cur_g;
  int    mg[4];   // reference model: current gains
  int    tg[4];   // targets for the next commit

  always @(posedge clk_i) edge_cnt++;

  // Monitor: every visible gain change or done pulse must match the next expected event.
  always @(negedge clk_i) begin
    cur_g = {g4_o, g3_o, g2_o, g1_o};
    if (mon_en && (cur_g !== prev_g || done_o !== 1'b0)) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output edge=%0d g=%h done=%b busy=%b (nothing expected)",
                 edge_cnt, cur_g, done_o, busy_o);
      end else begin
        mon_ev = expq.pop_front();
        if (cur_g !== mon_ev.g || done_o !== mon_ev.done || busy_o !== mon_ev.busy ||
            edge_cnt != int'(mon_ev.edge_no)) begin
          errors++;
          $display("FAIL ramp_event actual edge=%0d g=%h done=%b busy=%b required edge=%0d g=%h done=%b busy=%b",
                   edge_cnt, cur_g, done_o, busy_o, mon_ev.edge_no, mon_ev.g, mon_ev.done, mon_ev.busy);
        end
      end
    end
    prev_g = cur_g;
  end

  initial begin
    #900000;
    $display("FAIL watchdog edge=%0d required completion", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  function automatic int model_step(int g, int t, int s);
    int d = t - g;
    int a = (d < 0) ? -d : d;
    if (s == 0 || a <= s) return t;
    return (d > 0) ? g + s : g - s;
  endfunction

  function automatic gvec_t pack_model();
    gvec_t v;
    for (int i = 0; i < 4; i++) v[i] = GB'(mg[i]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_edge(input int e);
    while (edge_cnt < e) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive a commit (optionally with abort); k is the edge that samples it.
  task automatic do_commit(input int stp, input int dv, input bit sy, input bit ab, output int k);
    tgt_g1_i  = GB'(tg[0]);
    tgt_g2_i  = GB'(tg[1]);
    tgt_g3_i  = GB'(tg[2]);
    tgt_g4_i  = GB'(tg[3]);
    step_i    = GB'(stp);
    div_i     = DB'(dv);
    sync_en_i = sy;
    commit_i  = 1'b1;
    abort_i   = ab;
    k = edge_cnt + 1;
    tick();
    commit_i = 1'b0;
    abort_i  = 1'b0;
  endtask

  // Updates happen every dv+1 edges after 'start'; push up to max_ev of them.
  task automatic push_ramp(input int start, input int dv, input int stp, input int max_ev, output int last);
    int n = 0;
    bit dn = 1'b0;
    ev_t e;
    last = start;
    while (!dn && n < max_ev) begin
      n++;
      dn = 1'b1;
      for (int i = 0; i < 4; i++) begin
        mg[i] = model_step(mg[i], tg[i], stp);
        if (mg[i] != tg[i]) dn = 1'b0;
      end
      e.g       = pack_model();
      e.done    = dn;
      e.busy    = !dn;
      e.edge_no = 32'(start + n * (dv + 1));
      last      = start + n * (dv + 1);
      expq.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expq.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0", name, expq.size());
      expq.delete();
    end
    repeat (3) tick();
  endtask

  initial begin
    int k, k2, last, last2, c, stp, dv;
    for (int i = 0; i < 4; i++) begin mg[i] = 0; tg[i] = 0; end

    repeat (3) tick();
    chk("reset_g1", int'($signed(g1_o)), 0);
    chk("reset_g4", int'($signed(g4_o)), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    rst_i = 1'b0;
    tick();
    mon_en = 1'b1;

    // 1: positive ramp, step 10, every clock
    tg = '{100, 0, 0, 0};
    do_commit(10, 0, 0, 0, k);
    chk("t1_busy_after_commit", int'(busy_o), 1);
    push_ramp(k, 0, 10, 1000, last);
    drain("t1");
    chk("t1_busy_after_done", int'(busy_o), 0);

    // 2: negative, uneven last step, div 2
    tg = '{100, -25, 0, 0};
    do_commit(10, 2, 0, 0, k);
    push_ramp(k, 2, 10, 1000, last);
    drain("t2");

    // 3: full-scale jump with step 0
    tg = '{100, -25, 0, 32767};
    do_commit(0, 0, 0, 0, k);
    push_ramp(k, 0, 0, 1000, last);
    drain("t3a");
    tg[3] = -32768;
    do_commit(0, 0, 0, 0, k);
    push_ramp(k, 0, 0, 1000, last);
    drain("t3b");
    chk("t3_g4_min", int'($signed(g4_o)), -32768);

    // 4: sync on rising zero crossing, sine ramps -50..+50
    sin_i = SB'(-50);
    tick();
    tg = '{0, 0, 0, 0};
    do_commit(1000, 1, 1, 0, k);
    c = k + 50;
    push_ramp(c, 1, 1000, 1000, last);
    for (int j = 1; j <= 120; j++) begin
      sin_i = SB'((j < 100) ? -50 + j : 50);
      if (edge_cnt == c + 1) begin
        chk("t4_hold_before_update", int'($signed(g1_o)), 100);
        chk("t4_busy_after_cross", int'(busy_o), 1);
      end
      tick();
    end
    drain("t4");

    // 4b: 0 -> +5 is not a crossing
    sin_i = '0;
    repeat (3) tick();
    tg = '{5, 5, 5, 5};
    do_commit(1, 0, 1, 0, k);
    repeat (3) tick();
    sin_i = SB'(5);
    repeat (20) tick();
    chk("t4b_still_waiting", int'(busy_o), 1);
    chk("t4b_g1_unchanged", int'($signed(g1_o)), mg[0]);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t4b_abort_busy", int'(busy_o), 0);

    // 5a: retarget mid-ramp at g1=40
    tg = '{100, 0, 0, 0};
    do_commit(10, 1, 0, 0, k);
    push_ramp(k, 1, 10, 4, last);
    wait_edge(last);
    tg = '{0, 0, 0, 0};
    do_commit(10, 1, 0, 0, k2);
    push_ramp(last, 1, 10, 1000, last2);
    drain("t5a");

    // 5b: abort at g1=20
    tg = '{100, 0, 0, 0};
    do_commit(10, 1, 0, 0, k);
    push_ramp(k, 1, 10, 2, last);
    wait_edge(last);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("t5b_abort_busy", int'(busy_o), 0);
    chk("t5b_abort_hold", int'($signed(g1_o)), 20);
    repeat (10) tick();
    chk("t5b_hold_later", int'($signed(g1_o)), 20);

    // 6: commit and abort together while idle
    tg = '{999, 999, 999, 999};
    do_commit(10, 0, 0, 1, k);
    chk("t6_busy", int'(busy_o), 0);
    repeat (10) tick();
    chk("t6_g2_unchanged", int'($signed(g2_o)), mg[1]);

    // randomized ramps
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) tg[i] = int'($urandom_range(65535)) - 32768;
      stp = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(4000, 300));
      dv  = int'($urandom_range(3));
      do_commit(stp, dv, 0, 0, k);
      push_ramp(k, dv, stp, 1000, last);
      drain("rand");
    end
    tg = '{0, 0, 0, 0};
    do_commit(0, 0, 0, 0, k);
    push_ramp(k, 0, 0, 1000, last);
    drain("zero");

    // reset mid-ramp
    tg = '{1000, -1000, 500, -500};
    do_commit(100, 0, 0, 0, k);
    push_ramp(k, 0, 100, 5, last);
    wait_edge(last);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) mg[i] = 0;
    begin
      ev_t e;
      e.g = '0; e.done = 1'b0; e.busy = 1'b0; e.edge_no = 32'(last + 1);
      expq.push_back(e);
    end
    chk("rst_mid_busy", int'(busy_o), 0);
    chk("rst_mid_g2", int'($signed(g2_o)), 0);
    drain("rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
